// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_pkg
// Brief    : Shared types and helpers for the byte-enabled dual-port data RAM.
// Revision : 1.0 - initial release
// ============================================================================
package bram_pkg;

  // Widest word the lane-merge helper handles; callers cast to their width.
  localparam int c_merge_w     = 512;
  localparam int c_merge_lanes = c_merge_w / 8;

  typedef enum logic [1:0] {
    SEQ_RESET = 2'd0,
    SEQ_CLEAR = 2'd1,
    SEQ_RUN   = 2'd2
  } seq_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic logic [c_merge_w-1:0] merge(
    input logic [c_merge_w-1:0]     old_word,
    input logic [c_merge_w-1:0]     new_word,
    input logic [c_merge_lanes-1:0] strb
  );
    logic [c_merge_w-1:0] result;
    result = old_word;
    for (int i = 0; i < c_merge_lanes; i++) begin
      if (strb[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : bram_clear_seq
// Brief    : Post-reset sweep that zeroes every word, then raises ready.
// Revision : 1.0 - initial release
// ============================================================================
module bram_clear_seq #(
  parameter int IDX_WIDTH = 11,
  parameter bit CLEAR_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  output logic                 clr_en,
  output logic [IDX_WIDTH-1:0] clr_idx
);
  import bram_pkg::*;

  seq_state_t           r_state;
  logic [IDX_WIDTH-1:0] r_cnt;
  logic                 r_ready;

  // The RESET state already writes word 0 so that ready rises on edge DEPTH.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_RESET;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        SEQ_RESET, SEQ_CLEAR: begin
          if (!CLEAR_EN || (r_cnt == '1)) begin
            r_state <= SEQ_RUN;
            r_ready <= 1'b1;
          end else begin
            r_state <= SEQ_CLEAR;
            r_cnt   <= r_cnt + IDX_WIDTH'(1);
          end
        end
        SEQ_RUN: begin
          r_state <= SEQ_RUN;
        end
        default: begin
          r_state <= SEQ_RESET;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst_n so no zero-write lands on the array while reset is held.
  assign clr_en  = rst_n & CLEAR_EN & (r_state != SEQ_RUN);
  assign clr_idx = r_cnt;
  assign ready   = r_ready;

endmodule
`default_nettype wire

// File: rtl/bram_dp_be.sv
`default_nettype none
// ============================================================================
// Module   : bram_dp_be
// Brief    : Falling-edge dual-port RAM with byte strobes, write-first bypass.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dp_be #(
  parameter int    ADDR_WIDTH     = 13,
  parameter int    DATA_WIDTH     = 32,
  parameter string INIT_FILE      = "",
  parameter int    CLEAR_ON_RESET = 1,
  parameter int    OUT_REG        = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    w_err,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    r_valid,
  output logic                    r_err
);
  import bram_pkg::*;

  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_lsb   = clog2(c_bytes);
  localparam int c_idx_w = ADDR_WIDTH - c_lsb;
  localparam int c_depth = 2 ** c_idx_w;
  localparam bit c_clear = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");

  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  logic                  w_ready;
  logic                  w_clr_en;
  logic [c_idx_w-1:0]    w_clr_idx;
  logic                  w_wr_mis;
  logic                  w_rd_mis;
  logic [c_idx_w-1:0]    w_widx;
  logic [c_idx_w-1:0]    w_ridx;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_byp_word;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_mem_we;
  logic [c_idx_w-1:0]    w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_data;

  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_valid1;
  logic                  r_err1;
  logic                  r_w_err;

  bram_clear_seq #(
    .IDX_WIDTH (c_idx_w),
    .CLEAR_EN  (c_clear)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (w_ready),
    .clr_en  (w_clr_en),
    .clr_idx (w_clr_idx)
  );

  generate
    if (c_lsb == 0) begin : g_align_byte
      assign w_wr_mis = 1'b0;
      assign w_rd_mis = 1'b0;
    end else begin : g_align_word
      assign w_wr_mis = |w_addr[c_lsb-1:0];
      assign w_rd_mis = |r_addr[c_lsb-1:0];
    end
  endgenerate

  assign w_widx   = w_addr[ADDR_WIDTH-1:c_lsb];
  assign w_ridx   = r_addr[ADDR_WIDTH-1:c_lsb];
  assign w_wr_acc = w_ready & write_en & ~w_wr_mis;
  assign w_rd_acc = w_ready & read_en;
  assign w_bypass = w_wr_acc & ~w_rd_mis & (w_widx == w_ridx);

  assign w_wr_merged = DATA_WIDTH'(merge(c_merge_w'(r_mem[w_widx]), c_merge_w'(din),
                                         c_merge_lanes'(w_strb)));
  assign w_byp_word  = DATA_WIDTH'(merge(c_merge_w'(r_mem[w_ridx]), c_merge_w'(din),
                                         c_merge_lanes'(w_strb)));
  assign w_rd_word   = w_rd_mis ? '0 : (w_bypass ? w_byp_word : r_mem[w_ridx]);

  // Clear and user writes are mutually exclusive: one needs ready low, the other high.
  assign w_mem_we   = w_clr_en | w_wr_acc;
  assign w_mem_idx  = w_clr_en ? w_clr_idx : w_widx;
  assign w_mem_data = w_clr_en ? '0 : w_wr_merged;

  always_ff @(negedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_data;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout1  <= '0;
      r_valid1 <= 1'b0;
      r_err1   <= 1'b0;
      r_w_err  <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_dout1 <= w_rd_word;
      end
      r_valid1 <= w_rd_acc;
      r_err1   <= w_rd_acc & w_rd_mis;
      r_w_err  <= w_ready & write_en & w_wr_mis;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_dout2;
      logic                  r_valid2;
      logic                  r_err2;

      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout2  <= '0;
          r_valid2 <= 1'b0;
          r_err2   <= 1'b0;
        end else begin
          if (r_valid1) begin
            r_dout2 <= r_dout1;
          end
          r_valid2 <= r_valid1;
          r_err2   <= r_err1;
        end
      end

      assign dout    = r_dout2;
      assign r_valid = r_valid2;
      assign r_err   = r_err2;
    end else begin : g_out_direct
      assign dout    = r_dout1;
      assign r_valid = r_valid1;
      assign r_err   = r_err1;
    end
  endgenerate

  assign ready = w_ready;
  assign w_err = r_w_err;

endmodule
`default_nettype wire

// File: tb/tb_bram_dp_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_dp_be
// Brief    : Bench for bram_dp_be, one instance per output-register setting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_dp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en;
  logic [5:0]  w_addr;
  logic [3:0]  w_strb;
  logic [31:0] din;
  logic        read_en;
  logic [5:0]  r_addr;

  logic        ready0, w_err0, r_valid0, r_err0;
  logic [31:0] dout0;
  logic        ready1, w_err1, r_valid1, r_err1;
  logic [31:0] dout1;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: a word array plus the visible output state.
  logic [31:0] m_mem [16];
  bit          m_ready;
  int          m_edges;
  logic [31:0] m_d0, m_d1;
  bit          m_v0, m_e0, m_v1, m_e1, m_werr;

  always #5 clk = ~clk;

  bram_dp_be #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .INIT_FILE(""), .CLEAR_ON_RESET(1), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ready(ready0), .write_en(write_en), .w_addr(w_addr),
    .w_strb(w_strb), .din(din), .w_err(w_err0), .read_en(read_en), .r_addr(r_addr),
    .dout(dout0), .r_valid(r_valid0), .r_err(r_err0));

  bram_dp_be #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .INIT_FILE(""), .CLEAR_ON_RESET(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ready(ready1), .write_en(write_en), .w_addr(w_addr),
    .w_strb(w_strb), .din(din), .w_err(w_err1), .read_en(read_en), .r_addr(r_addr),
    .dout(dout1), .r_valid(r_valid1), .r_err(r_err1));

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old_w[8*b +: 8] = new_w[8*b +: 8];
    return old_w;
  endfunction

  task automatic model_edge();
    bit          wmis;
    logic [31:0] word;
    if (!rst_n) return;
    wmis = (w_addr[1:0] != 2'b00);
    if (m_v0) m_d1 = m_d0;
    m_v1   = m_v0;
    m_e1   = m_e0;
    m_werr = m_ready && write_en && wmis;
    if (m_ready && read_en) begin
      m_v0 = 1'b1;
      if (r_addr[1:0] != 2'b00) begin
        m_d0 = 32'h0;
        m_e0 = 1'b1;
      end else begin
        word = m_mem[r_addr[5:2]];
        if (write_en && !wmis && (w_addr[5:2] == r_addr[5:2])) word = lanes(word, din, w_strb);
        m_d0 = word;
        m_e0 = 1'b0;
      end
    end else begin
      m_v0 = 1'b0;
      m_e0 = 1'b0;
    end
    if (m_ready && write_en && !wmis) m_mem[w_addr[5:2]] = lanes(m_mem[w_addr[5:2]], din, w_strb);
    if (!m_ready) begin
      m_edges++;
      if (m_edges == 16) begin
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      end
    end
  endtask

  task automatic cycle(input logic we, input logic [5:0] wa, input logic [3:0] ws,
                       input logic [31:0] wd, input logic re, input logic [5:0] ra);
    write_en = we; w_addr = wa; w_strb = ws; din = wd; read_en = re; r_addr = ra;
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    write_en = 1'b0; read_en = 1'b0;
    m_ready = 1'b0; m_edges = 0;
    m_d0 = '0; m_d1 = '0; m_v0 = 0; m_e0 = 0; m_v1 = 0; m_e1 = 0; m_werr = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    hold_reset(2);
    checks++;
    if ({ready0, w_err0, r_valid0, r_err0, dout0} !== 36'h0) begin
      errors++; $display("FAIL reset_p0 got=%h exp=0", {ready0, w_err0, r_valid0, r_err0, dout0});
    end
    checks++;
    if ({ready1, w_err1, r_valid1, r_err1, dout1} !== 36'h0) begin
      errors++; $display("FAIL reset_p1 got=%h exp=0", {ready1, w_err1, r_valid1, r_err1, dout1});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 6'h00, 4'h0, 32'h0, 1, 6'h00);
      checks++;
      if (ready0 !== (i == 16) || ready1 !== (i == 16) || r_valid0 !== 1'b0) begin
        errors++; $display("FAIL clear_ready edge=%0d got=%b%b v=%b exp=%b", i, ready0, ready1, r_valid0, i == 16);
      end
    end
    cycle(0, 6'h00, 4'h0, 32'h0, 1, 6'h3C);
    checks++;
    if ({r_valid0, r_err0, dout0} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL clear_read got v=%b e=%b d=%h exp v=1 e=0 d=0", r_valid0, r_err0, dout0);
    end
    cycle(0, 6'h00, 4'h0, 32'h0, 0, 6'h00);
    checks++;
    if ({r_valid0, r_valid1, r_err1, dout1} !== {3'b010, 32'h0}) begin
      errors++; $display("FAIL clear_read_reg got v0=%b v1=%b e1=%b d1=%h exp 0 1 0 0", r_valid0, r_valid1, r_err1, dout1);
    end
  endtask

  task automatic test_strobes();
    cycle(1, 6'h08, 4'hF, 32'hAABBCCDD, 0, 6'h00);
    cycle(1, 6'h08, 4'b0101, 32'h11223344, 0, 6'h00);
    cycle(0, 6'h00, 4'h0, 32'h0, 1, 6'h08);
    checks++;
    if (dout0 !== 32'hAA22CC44 || r_valid0 !== 1'b1 || dout0 !== m_d0) begin
      errors++; $display("FAIL strobe got=%h v=%b exp=AA22CC44 v=1", dout0, r_valid0);
    end
  endtask

  task automatic test_bypass();
    cycle(1, 6'h10, 4'hF, 32'h01020304, 0, 6'h00);
    cycle(1, 6'h10, 4'b0011, 32'hDEADBEEF, 1, 6'h10);
    checks++;
    if (dout0 !== 32'h0102BEEF || r_valid0 !== 1'b1) begin
      errors++; $display("FAIL bypass got=%h v=%b exp=0102BEEF v=1", dout0, r_valid0);
    end
    cycle(0, 6'h00, 4'h0, 32'h0, 1, 6'h10);
    checks++;
    if (dout0 !== 32'h0102BEEF || dout1 !== 32'h0102BEEF || r_valid1 !== 1'b1) begin
      errors++; $display("FAIL bypass_stored got=%h/%h exp=0102BEEF", dout0, dout1);
    end
  endtask

  task automatic test_misalign();
    cycle(1, 6'h0A, 4'hF, 32'hFFFFFFFF, 0, 6'h00);
    checks++;
    if (w_err0 !== 1'b1 || w_err1 !== 1'b1) begin
      errors++; $display("FAIL werr_pulse got=%b%b exp=11", w_err0, w_err1);
    end
    cycle(0, 6'h00, 4'h0, 32'h0, 0, 6'h00);
    checks++;
    if (w_err0 !== 1'b0) begin
      errors++; $display("FAIL werr_width got=%b exp=0", w_err0);
    end
    // Rejected write to the same word must neither land nor bypass.
    cycle(1, 6'h0B, 4'hF, 32'h55555555, 1, 6'h08);
    checks++;
    if (dout0 !== 32'hAA22CC44 || w_err0 !== 1'b1) begin
      errors++; $display("FAIL mis_nobypass got=%h werr=%b exp=AA22CC44 werr=1", dout0, w_err0);
    end
    cycle(0, 6'h00, 4'h0, 32'h0, 1, 6'h0A);
    checks++;
    if ({r_valid0, r_err0, dout0} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL mis_read got v=%b e=%b d=%h exp v=1 e=1 d=0", r_valid0, r_err0, dout0);
    end
  endtask

  task automatic test_out_reg();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'hAA22CC44;
    cycle(1, 6'h00, 4'hF, 32'h11111111, 0, 6'h00);
    cycle(1, 6'h04, 4'hF, 32'h22222222, 0, 6'h00);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 6'h00, 4'h0, 32'h0, (k < 3), 6'(4 * k));
      checks++;
      if (r_valid0 !== (k < 3) || r_valid1 !== (k >= 1 && k < 4) ||
          (k < 3 && dout0 !== exp_d[k]) || (k >= 1 && k < 4 && dout1 !== exp_d[k-1])) begin
        errors++; $display("FAIL out_reg k=%0d got v0=%b d0=%h v1=%b d1=%h", k, r_valid0, dout0, r_valid1, dout1);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] wa, ra;
    for (int c = 0; c < 300; c++) begin
      wa = ($urandom_range(0, 7) == 0) ? 6'($urandom) : {4'($urandom), 2'b00};
      ra = ($urandom_range(0, 3) == 0) ? wa :
           (($urandom_range(0, 7) == 0) ? 6'($urandom) : {4'($urandom), 2'b00});
      cycle(1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom), ra);
      checks++;
      if ({ready0, r_valid0, r_err0, w_err0, dout0} !== {m_ready, m_v0, m_e0, m_werr, m_d0}) begin
        errors++; $display("FAIL random_p0 cyc=%0d got=%h exp=%h", c,
                           {ready0, r_valid0, r_err0, w_err0, dout0}, {m_ready, m_v0, m_e0, m_werr, m_d0});
      end
      checks++;
      if ({ready1, r_valid1, r_err1, w_err1, dout1} !== {m_ready, m_v1, m_e1, m_werr, m_d1}) begin
        errors++; $display("FAIL random_p1 cyc=%0d got=%h exp=%h", c,
                           {ready1, r_valid1, r_err1, w_err1, dout1}, {m_ready, m_v1, m_e1, m_werr, m_d1});
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    hold_reset(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) cycle(1, 6'h20, 4'hF, 32'hFFFFFFFF, 1, 6'h20);
    checks++;
    if (ready0 !== 1'b0 || r_valid0 !== 1'b0) begin
      errors++; $display("FAIL midclear_pre got rdy=%b v=%b exp 0 0", ready0, r_valid0);
    end
    hold_reset(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 6'h00, 4'h0, 32'h0, 0, 6'h00);
      checks++;
      if (ready0 !== (i == 16) || ready1 !== (i == 16)) begin
        errors++; $display("FAIL midclear_ready edge=%0d got=%b%b exp=%b", i, ready0, ready1, i == 16);
      end
    end
    for (int w = 0; w < 17; w++) begin
      cycle(0, 6'h00, 4'h0, 32'h0, (w < 16), 6'(4 * w));
      checks++;
      if (r_valid0 !== (w < 16) || dout0 !== 32'h0 || r_valid1 !== (w >= 1) || dout1 !== 32'h0) begin
        errors++; $display("FAIL midclear_zero w=%0d got v0=%b d0=%h v1=%b d1=%h", w, r_valid0, dout0, r_valid1, dout1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; write_en = 1'b0; read_en = 1'b0;
    w_addr = '0; r_addr = '0; w_strb = '0; din = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    test_reset();
    test_strobes();
    test_bypass();
    test_misalign();
    test_out_reg();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
